// File: rtl/avl_mem_responder.sv
// avl_mem_responder: Avalon-MM memory responder with byte-masked writes and queued, in-order read bursts.
// Latency: first read beat READ_LATENCY cycles after command accept; write beats commit at the accepting edge.
// Backpressure: avl_ready drops on a full read queue, on a first write beat while reads are pending, on a
//   read/write collision, and (with AVL_RESP_RANDSTALL_EN defined) on pseudo-random LFSR stall cycles.

// Small synchronous FIFO used as the read-command queue; head is visible combinationally.
module avl_rq_fifo #(
  parameter int WIDTH     = 8,
  parameter int DEPTH_LOG = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_push_vld,
  input  logic [WIDTH-1:0]     i_push_dat,
  input  logic                 i_pop,
  output logic [WIDTH-1:0]     o_head_dat,
  output logic                 o_head_vld,
  output logic [DEPTH_LOG:0]   o_count
);
  localparam int DEPTH = 1 << DEPTH_LOG;

  logic [WIDTH-1:0]     r_mem [DEPTH];
  logic [DEPTH_LOG-1:0] r_wr_ptr;
  logic [DEPTH_LOG-1:0] r_rd_ptr;
  logic [DEPTH_LOG:0]   r_count;

  // entry storage; contents are don't-care until pushed, so no reset
  always_ff @(posedge clk) begin
    if (i_push_vld) r_mem[r_wr_ptr] <= i_push_dat;
  end

  // pointers and occupancy; caller never pushes when full nor pops when empty
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push_vld) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)      r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({i_push_vld, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head_dat = r_mem[r_rd_ptr];
  assign o_head_vld = (r_count != '0);
  assign o_count    = r_count;
endmodule

module avl_mem_responder #(
  parameter int AVL_ADDR       = 30,
  parameter int AVL_SIZE       = 3,
  parameter int AVL_DATA_WIDTH = 256,
  parameter int AVL_BE         = 32,
  parameter int MEM_DEPTH_BITS = 10,
  parameter int READ_LATENCY   = 4,
  parameter int RQ_DEPTH_LOG   = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [AVL_ADDR-1:0]       avl_addr,
  input  logic [AVL_SIZE-1:0]       avl_size,
  input  logic [AVL_DATA_WIDTH-1:0] avl_wdata,
  input  logic [AVL_BE-1:0]         avl_be,
  input  logic                      avl_write_req,
  input  logic                      avl_read_req,
  input  logic                      avl_burstbegin,
  output logic                      avl_ready,
  output logic [AVL_DATA_WIDTH-1:0] avl_rdata,
  output logic                      avl_rdata_valid,
  output logic                      proto_err
);
  localparam int MEM_WORDS = 1 << MEM_DEPTH_BITS;
  localparam int TS_W      = 16;
  localparam int RQ_W      = MEM_DEPTH_BITS + AVL_SIZE + TS_W;
  // The issuing beat is registered into avl_rdata, so a head becomes eligible one cycle early.
  localparam logic [TS_W-1:0]       ISSUE_AGE = TS_W'(READ_LATENCY - 1);
  localparam logic [RQ_DEPTH_LOG:0] RQ_DEPTH  = (RQ_DEPTH_LOG + 1)'(1 << RQ_DEPTH_LOG);

  typedef enum logic {ST_IDLE, ST_WR_BURST} wr_state_t;

  typedef struct packed {
    logic [MEM_DEPTH_BITS-1:0] addr;
    logic [AVL_SIZE-1:0]       size;
    logic [TS_W-1:0]           stamp;
  } rd_cmd_t;

  logic [AVL_DATA_WIDTH-1:0] r_mem [MEM_WORDS];

  wr_state_t                 r_state;
  wr_state_t                 w_state_nxt;
  logic [MEM_DEPTH_BITS-1:0] r_wr_addr;
  logic [AVL_SIZE-1:0]       r_wr_left;
  logic [TS_W-1:0]           r_time;
  logic [AVL_SIZE-1:0]       r_beat_idx;
  logic [AVL_DATA_WIDTH-1:0] r_rdata;
  logic                      r_rdata_vld;
  logic                      r_proto_err;

  logic                      w_stall;
  logic                      w_go;
  logic                      w_ready;
  logic                      w_wr_en;
  logic [MEM_DEPTH_BITS-1:0] w_wr_word;
  logic [AVL_SIZE-1:0]       w_wr_left_nxt;
  logic                      w_err_set;
  logic                      w_rq_push;
  logic                      w_rq_pop;
  logic [RQ_W-1:0]           w_rq_head;
  logic                      w_rq_head_vld;
  logic [RQ_DEPTH_LOG:0]     w_rq_count;
  logic                      w_rd_ok;
  logic                      w_wr_ok;
  rd_cmd_t                   w_push_cmd;
  rd_cmd_t                   w_head;
  logic [TS_W-1:0]           w_age;
  logic                      w_issue;
  logic                      w_last;
  logic [MEM_DEPTH_BITS-1:0] w_rd_word;
  logic                      w_unused_addr_hi;

  // Address bits above the backing-store depth are deliberately ignored.
  assign w_unused_addr_hi = &{1'b0, avl_addr[AVL_ADDR-1:MEM_DEPTH_BITS]};

`ifdef AVL_RESP_RANDSTALL_EN
  logic [15:0] r_lfsr;

  // Fibonacci LFSR x^16+x^14+x^13+x^11+1, free-running; bit0 withholds avl_ready
  always_ff @(posedge clk) begin
    if (!reset) r_lfsr <= 16'hACE1;
    else        r_lfsr <= {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[15:1]};
  end

  assign w_stall = r_lfsr[0];
`else
  assign w_stall = 1'b0;
`endif

  assign w_go    = reset && !w_stall;
  // The queue holds a command until its last beat issues, so an active burst occupies a slot.
  assign w_rd_ok = (w_rq_count < RQ_DEPTH);
  // Writes start only with nothing queued or in flight, so they never race earlier reads.
  assign w_wr_ok = (w_rq_count == '0);

  assign w_push_cmd = '{addr: avl_addr[MEM_DEPTH_BITS-1:0], size: avl_size, stamp: r_time};

  // Ready is qualified by which request is presented so a beat is never "taken" and then dropped.
  always_comb begin
    w_state_nxt   = r_state;
    w_ready       = 1'b0;
    w_wr_en       = 1'b0;
    w_wr_word     = r_wr_addr;
    w_wr_left_nxt = r_wr_left;
    w_rq_push     = 1'b0;
    w_err_set     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (avl_read_req && avl_write_req) begin
          w_err_set = 1'b1;
        end else if (avl_write_req) begin
          w_ready = w_go && w_wr_ok;
          if (w_ready) begin
            if (!avl_burstbegin || avl_size == '0) begin
              w_err_set = 1'b1;
            end else begin
              w_wr_en       = 1'b1;
              w_wr_word     = avl_addr[MEM_DEPTH_BITS-1:0];
              w_wr_left_nxt = avl_size - 1'b1;
              if (avl_size != AVL_SIZE'(1)) w_state_nxt = ST_WR_BURST;
            end
          end
        end else if (avl_read_req) begin
          w_ready = w_go && w_rd_ok;
          if (w_ready) begin
            if (avl_size == '0) w_err_set = 1'b1;
            else                w_rq_push = 1'b1;
          end
        end else begin
          w_ready = w_go && (w_rd_ok || w_wr_ok);
        end
      end
      ST_WR_BURST: begin
        w_ready = w_go;
        if (avl_write_req && w_go) begin
          w_wr_en       = 1'b1;
          w_wr_left_nxt = r_wr_left - 1'b1;
          if (r_wr_left == AVL_SIZE'(1)) w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign avl_ready = w_ready;

  // write FSM state and the running burst address / beats-remaining count
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_wr_addr <= '0;
      r_wr_left <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_wr_en) begin
        r_wr_addr <= w_wr_word + 1'b1;
        r_wr_left <= w_wr_left_nxt;
      end
    end
  end

  // byte-masked backing-store write; not reset so contents survive reset
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      for (int b = 0; b < AVL_BE; b++) begin
        if (avl_be[b]) r_mem[w_wr_word][b*8 +: 8] <= avl_wdata[b*8 +: 8];
      end
    end
  end

  avl_rq_fifo #(
    .WIDTH     (RQ_W),
    .DEPTH_LOG (RQ_DEPTH_LOG)
  ) u_rq (
    .clk        (clk),
    .reset      (reset),
    .i_push_vld (w_rq_push),
    .i_push_dat (w_push_cmd),
    .i_pop      (w_rq_pop),
    .o_head_dat (w_rq_head),
    .o_head_vld (w_rq_head_vld),
    .o_count    (w_rq_count)
  );

  assign w_head    = rd_cmd_t'(w_rq_head);
  assign w_age     = r_time - w_head.stamp;
  // Mid-burst beats go out every cycle; a new burst waits until its latency has elapsed.
  assign w_issue   = w_rq_head_vld && ((r_beat_idx != '0) || (w_age >= ISSUE_AGE));
  assign w_last    = (r_beat_idx == w_head.size - 1'b1);
  assign w_rq_pop  = w_issue && w_last;
  assign w_rd_word = w_head.addr + MEM_DEPTH_BITS'(r_beat_idx);

  // free-running timestamp and sticky protocol error flag
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_time      <= '0;
      r_proto_err <= 1'b0;
    end else begin
      r_time <= r_time + 1'b1;
      if (w_err_set) r_proto_err <= 1'b1;
    end
  end

  // read beat issue: register data and valid, step through the head burst
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_beat_idx  <= '0;
      r_rdata_vld <= 1'b0;
      r_rdata     <= '0;
    end else begin
      r_rdata_vld <= w_issue;
      if (w_issue) begin
        r_rdata    <= r_mem[w_rd_word];
        r_beat_idx <= w_last ? '0 : r_beat_idx + 1'b1;
      end
    end
  end

  assign avl_rdata       = r_rdata;
  assign avl_rdata_valid = r_rdata_vld;
  assign proto_err       = r_proto_err;
endmodule

// File: tb/tb_avl_mem_responder.sv
// Directed bench for avl_mem_responder: reset, single beats, wrapping bursts, byte enables,
// queued back-to-back reads, protocol errors and reset during a read burst.
module tb_avl_mem_responder;
  localparam int AW = 30;
  localparam int SW = 3;
  localparam int DW = 256;
  localparam int BW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [AW-1:0] avl_addr = '0;
  logic [SW-1:0] avl_size = '0;
  logic [DW-1:0] avl_wdata = '0;
  logic [BW-1:0] avl_be = '0;
  logic          avl_write_req = 1'b0;
  logic          avl_read_req = 1'b0;
  logic          avl_burstbegin = 1'b0;
  logic          avl_ready;
  logic [DW-1:0] avl_rdata;
  logic          avl_rdata_valid;
  logic          proto_err;

  avl_mem_responder dut (
    .clk             (clk),
    .reset           (reset),
    .avl_addr        (avl_addr),
    .avl_size        (avl_size),
    .avl_wdata       (avl_wdata),
    .avl_be          (avl_be),
    .avl_write_req   (avl_write_req),
    .avl_read_req    (avl_read_req),
    .avl_burstbegin  (avl_burstbegin),
    .avl_ready       (avl_ready),
    .avl_rdata       (avl_rdata),
    .avl_rdata_valid (avl_rdata_valid),
    .proto_err       (proto_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            c;
    logic [DW-1:0] d;
  } beat_t;
  beat_t beats[$];

  always @(negedge clk) begin
    if (avl_rdata_valid === 1'b1) begin
      beat_t b;
      b.c = cyc;
      b.d = avl_rdata;
      beats.push_back(b);
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle_inputs();
    avl_write_req  = 1'b0;
    avl_read_req   = 1'b0;
    avl_burstbegin = 1'b0;
    avl_size       = '0;
    avl_addr       = '0;
    avl_be         = '0;
    avl_wdata      = '0;
  endtask

  task automatic drive_write(input logic [AW-1:0] a, input logic [SW-1:0] s, input logic [DW-1:0] d,
                             input logic [BW-1:0] be_i, input logic b, input string tag);
    bit acc = 1'b0;
    avl_addr = a; avl_size = s; avl_wdata = d; avl_be = be_i; avl_burstbegin = b;
    avl_read_req = 1'b0; avl_write_req = 1'b1;
    for (int i = 0; i < 200 && !acc; i++) begin
      #1;
      acc = (avl_ready === 1'b1);
      @(posedge clk);
      #1;
    end
    avl_write_req = 1'b0; avl_burstbegin = 1'b0;
    if (!acc) begin
      n_checks++;
      $display("FAIL %s_accept: avl_ready never 1 within 200 cycles", tag);
    end
  endtask

  task automatic drive_read(input logic [AW-1:0] a, input logic [SW-1:0] s, input string tag,
                            output int t, output int waits);
    bit acc = 1'b0;
    t = -1; waits = 0;
    avl_addr = a; avl_size = s; avl_write_req = 1'b0; avl_read_req = 1'b1;
    for (int i = 0; i < 200 && !acc; i++) begin
      #1;
      acc = (avl_ready === 1'b1);
      if (acc) t = cyc;
      else     waits++;
      @(posedge clk);
      #1;
    end
    avl_read_req = 1'b0;
    if (!acc) begin
      n_checks++;
      $display("FAIL %s_accept: avl_ready never 1 within 200 cycles", tag);
    end
  endtask

  task automatic pulse_reset();
    idle_inputs();
    reset = 1'b0;
    tick(2);
    reset = 1'b1;
    tick(1);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    avl_read_req = 1'b1; avl_size = 3'd1;
    tick(3);
    n_checks++;
    if (avl_ready !== 1'b0) $display("FAIL rst_ready: got %b want 0", avl_ready); else n_pass++;
    n_checks++;
    if (avl_rdata_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", avl_rdata_valid); else n_pass++;
    n_checks++;
    if (avl_rdata !== '0) $display("FAIL rst_rdata: got %h want 0", avl_rdata); else n_pass++;
    n_checks++;
    if (proto_err !== 1'b0) $display("FAIL rst_err: got %b want 0", proto_err); else n_pass++;
    idle_inputs();
    reset = 1'b1;
    tick(1);
    n_checks++;
    if (avl_ready !== 1'b1) $display("FAIL rst_release_ready: got %b want 1", avl_ready); else n_pass++;
  endtask

  task automatic test_single();
    int t, w, got_c;
    logic [DW-1:0] exp_d, got_d;
    exp_d = {32{8'hA5}};
    drive_write(30'h10, 3'd1, exp_d, '1, 1'b1, "single_wr");
    beats.delete();
    drive_read(30'h10, 3'd1, "single_rd", t, w);
    tick(8);
    got_c = (beats.size() > 0) ? beats[0].c : -1;
    got_d = (beats.size() > 0) ? beats[0].d : '0;
    n_checks++;
    if (beats.size() != 1) $display("FAIL single_nbeats: got %0d want 1", beats.size()); else n_pass++;
    n_checks++;
    if (got_c != t + 4) $display("FAIL single_latency: beat at cycle %0d want %0d", got_c, t + 4); else n_pass++;
    n_checks++;
    if (got_d !== exp_d) $display("FAIL single_data: got %h want %h", got_d, exp_d); else n_pass++;
    tick(3);
    n_checks++;
    if (avl_rdata_valid !== 1'b0 || avl_rdata !== exp_d)
      $display("FAIL single_hold: valid %b rdata %h want 0 / %h", avl_rdata_valid, avl_rdata, exp_d);
    else n_pass++;
  endtask

  task automatic test_wrap();
    int t, w, got_c;
    logic [DW-1:0] got_d;
    drive_write(30'h3FE, 3'd4, DW'(1), '1, 1'b1, "wrap_b0");
    for (int k = 1; k < 4; k++) drive_write(30'h0, 3'd0, DW'(k + 1), '1, 1'b0, "wrap_bn");
    idle_inputs();
    beats.delete();
    drive_read(30'h3FE, 3'd4, "wrap_rd", t, w);
    tick(12);
    n_checks++;
    if (beats.size() != 4) $display("FAIL wrap_nbeats: got %0d want 4", beats.size()); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      got_c = (beats.size() > k) ? beats[k].c : -1;
      got_d = (beats.size() > k) ? beats[k].d : '0;
      n_checks++;
      if (got_c != t + 4 + k || got_d !== DW'(k + 1))
        $display("FAIL wrap_beat%0d: cycle %0d data %0h want cycle %0d data %0h", k, got_c, got_d, t + 4 + k, k + 1);
      else n_pass++;
    end
    // upper address bits ignored: 0x400 maps to word 0
    beats.delete();
    drive_read(30'h400, 3'd2, "wrap_rd0", t, w);
    tick(10);
    got_d = (beats.size() > 0) ? beats[0].d : '0;
    n_checks++;
    if (got_d !== DW'(3)) $display("FAIL wrap_word0: got %0h want 3", got_d); else n_pass++;
    got_d = (beats.size() > 1) ? beats[1].d : '0;
    n_checks++;
    if (got_d !== DW'(4)) $display("FAIL wrap_word1: got %0h want 4", got_d); else n_pass++;
  endtask

  task automatic test_byte_enable();
    int t, w;
    logic [DW-1:0] got_d, exp_d;
    exp_d = {{31{8'hFF}}, 8'h00};
    drive_write(30'h20, 3'd1, '1, '1, 1'b1, "be_full");
    drive_write(30'h20, 3'd1, '0, 32'h0000_0001, 1'b1, "be_byte0");
    beats.delete();
    drive_read(30'h20, 3'd1, "be_rd", t, w);
    tick(8);
    got_d = (beats.size() > 0) ? beats[0].d : '0;
    n_checks++;
    if (got_d !== exp_d) $display("FAIL be_data: got %h want %h", got_d, exp_d); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int t[5];
    int w[5];
    int gaps, got_c;
    logic [DW-1:0] got_d;
    drive_write(30'h40, 3'd5, DW'(32'h100), '1, 1'b1, "b2b_wa");
    for (int k = 1; k < 5; k++) drive_write(30'h0, 3'd0, DW'(32'h100 + k), '1, 1'b0, "b2b_wa");
    drive_write(30'h45, 3'd5, DW'(32'h105), '1, 1'b1, "b2b_wb");
    for (int k = 1; k < 5; k++) drive_write(30'h0, 3'd0, DW'(32'h105 + k), '1, 1'b0, "b2b_wb");
    idle_inputs();
    beats.delete();
    for (int r = 0; r < 5; r++) drive_read(AW'(32'h40 + 2 * r), 3'd2, "b2b_rd", t[r], w[r]);
    tick(25);
    for (int r = 0; r < 4; r++) begin
      n_checks++;
      if (w[r] != 0) $display("FAIL b2b_nostall%0d: waited %0d cycles want 0", r, w[r]); else n_pass++;
    end
    n_checks++;
    if (w[4] < 1) $display("FAIL b2b_fifth_stall: waited %0d cycles want >=1", w[4]); else n_pass++;
    n_checks++;
    if (beats.size() != 10) $display("FAIL b2b_nbeats: got %0d want 10", beats.size()); else n_pass++;
    got_c = (beats.size() > 0) ? beats[0].c : -1;
    n_checks++;
    if (got_c != t[0] + 4) $display("FAIL b2b_first: cycle %0d want %0d", got_c, t[0] + 4); else n_pass++;
    gaps = 0;
    for (int k = 1; k < beats.size(); k++) if (beats[k].c != beats[k-1].c + 1) gaps++;
    n_checks++;
    if (gaps != 0) $display("FAIL b2b_gaps: got %0d gaps want 0", gaps); else n_pass++;
    for (int k = 0; k < 10; k++) begin
      got_d = (beats.size() > k) ? beats[k].d : '0;
      n_checks++;
      if (got_d !== DW'(32'h100 + k)) $display("FAIL b2b_data%0d: got %0h want %0h", k, got_d, 32'h100 + k);
      else n_pass++;
    end
    n_checks++;
    if (proto_err !== 1'b0) $display("FAIL b2b_err: got %b want 0", proto_err); else n_pass++;
  endtask

  task automatic test_protocol_errors();
    int t, w;
    logic [DW-1:0] got_d, exp_d;
    exp_d = {{31{8'hFF}}, 8'h00};
    // collision: both requests in IDLE, a write of zeros that must not land
    beats.delete();
    avl_addr = 30'h20; avl_size = 3'd1; avl_wdata = '0; avl_be = '1; avl_burstbegin = 1'b1;
    avl_read_req = 1'b1; avl_write_req = 1'b1;
    #1;
    n_checks++;
    if (avl_ready !== 1'b0) $display("FAIL coll_ready: got %b want 0", avl_ready); else n_pass++;
    tick(1);
    idle_inputs();
    tick(6);
    n_checks++;
    if (proto_err !== 1'b1) $display("FAIL coll_err: got %b want 1", proto_err); else n_pass++;
    n_checks++;
    if (beats.size() != 0) $display("FAIL coll_nobeat: got %0d beats want 0", beats.size()); else n_pass++;
    drive_read(30'h20, 3'd1, "coll_rd", t, w);
    tick(8);
    got_d = (beats.size() > 0) ? beats[0].d : '0;
    n_checks++;
    if (got_d !== exp_d) $display("FAIL coll_mem: got %h want %h", got_d, exp_d); else n_pass++;
    n_checks++;
    if (proto_err !== 1'b1) $display("FAIL coll_sticky: got %b want 1", proto_err); else n_pass++;
    pulse_reset();
    n_checks++;
    if (proto_err !== 1'b0) $display("FAIL coll_clear: got %b want 0", proto_err); else n_pass++;
    // zero burstcount read: accepted, discarded
    beats.delete();
    drive_read(30'h20, 3'd0, "zero_rd", t, w);
    tick(8);
    n_checks++;
    if (w != 0 || beats.size() != 0 || proto_err !== 1'b1)
      $display("FAIL zero_read: waits %0d beats %0d err %b want 0/0/1", w, beats.size(), proto_err);
    else n_pass++;
    pulse_reset();
    // first write beat without burstbegin: accepted, discarded
    drive_write(30'h20, 3'd1, '0, '1, 1'b0, "nobb_wr");
    tick(1);
    n_checks++;
    if (proto_err !== 1'b1) $display("FAIL nobb_err: got %b want 1", proto_err); else n_pass++;
    pulse_reset();
    beats.delete();
    drive_read(30'h20, 3'd1, "nobb_rd", t, w);
    tick(8);
    got_d = (beats.size() > 0) ? beats[0].d : '0;
    n_checks++;
    if (got_d !== exp_d) $display("FAIL nobb_mem: got %h want %h", got_d, exp_d); else n_pass++;
  endtask

  task automatic test_reset_mid_read();
    int t, w, late;
    logic [DW-1:0] got_d;
    drive_write(30'h60, 3'd4, DW'(32'hA0), '1, 1'b1, "rmr_wr");
    for (int k = 1; k < 4; k++) drive_write(30'h0, 3'd0, DW'(32'hA0 + k), '1, 1'b0, "rmr_wr");
    idle_inputs();
    beats.delete();
    drive_read(30'h60, 3'd4, "rmr_rd", t, w);
    while (cyc < t + 6) tick(1);
    reset = 1'b0;
    #1;
    n_checks++;
    if (avl_ready !== 1'b0) $display("FAIL rmr_ready: got %b want 0", avl_ready); else n_pass++;
    tick(1);
    n_checks++;
    if (avl_rdata_valid !== 1'b0) $display("FAIL rmr_valid_next: got %b want 0", avl_rdata_valid); else n_pass++;
    tick(2);
    n_checks++;
    if (avl_rdata_valid !== 1'b0 || avl_rdata !== '0)
      $display("FAIL rmr_in_reset: valid %b rdata %h want 0/0", avl_rdata_valid, avl_rdata);
    else n_pass++;
    reset = 1'b1;
    tick(10);
    late = 0;
    foreach (beats[k]) if (beats[k].c > t + 6) late++;
    n_checks++;
    if (beats.size() != 3 || late != 0)
      $display("FAIL rmr_beats: got %0d beats (%0d after reset) want 3 (0)", beats.size(), late);
    else n_pass++;
    got_d = (beats.size() > 2) ? beats[2].d : '0;
    n_checks++;
    if (got_d !== DW'(32'hA2)) $display("FAIL rmr_third: got %0h want a2", got_d); else n_pass++;
    beats.delete();
    drive_read(30'h60, 3'd1, "rmr_rd2", t, w);
    tick(8);
    got_d = (beats.size() > 0) ? beats[0].d : '0;
    n_checks++;
    if (got_d !== DW'(32'hA0)) $display("FAIL rmr_mem_kept: got %0h want a0", got_d); else n_pass++;
  endtask

  initial begin
    idle_inputs();
    #1;
    test_reset();
    test_single();
    test_wrap();
    test_byte_enable();
    test_back_to_back();
    test_protocol_errors();
    test_reset_mid_read();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/avl_mem_responder.md
AVL_MEM_RESPONDER -- requirements
Module: avl_mem_responder

Interface
REQ-001 SHALL have parameter AVL_ADDR, 30, Avalon word-address width.
REQ-002 SHALL have parameter AVL_SIZE, 3, burstcount width.
REQ-003 SHALL have parameter AVL_DATA_WIDTH, 256, beat data width.
REQ-004 SHALL have parameter AVL_BE, 32, byte-enable width (AVL_DATA_WIDTH/8).
REQ-005 SHALL have parameter MEM_DEPTH_BITS, 10, log2 of backing-store words.
REQ-006 SHALL have parameter READ_LATENCY, 4, command-accept to first read beat in cycles (min 2).
REQ-007 SHALL have parameter RQ_DEPTH_LOG, 2, log2 of read-command queue depth.
REQ-008 Ports (name direction width meaning):
 clk in 1 sole clock, rising edge;
 reset in 1 synchronous active-low reset (0 = in reset);
 avl_addr in AVL_ADDR burst start word address;
 avl_size in AVL_SIZE burstcount;
 avl_wdata in AVL_DATA_WIDTH write beat data;
 avl_be in AVL_BE per-byte write enable;
 avl_write_req in 1 write beat valid;
 avl_read_req in 1 read command valid;
 avl_burstbegin in 1 first write beat marker;
 avl_ready out 1 responder accepts current command/beat;
 avl_rdata out AVL_DATA_WIDTH read beat data;
 avl_rdata_valid out 1 read beat valid;
 proto_err out 1 sticky protocol-violation flag.
REQ-009 One clock; reset synchronous, active-low, named reset.

Function
REQ-010 Backing store SHALL be 2**MEM_DEPTH_BITS words of AVL_DATA_WIDTH; beat k of a burst addresses (avl_addr[MEM_DEPTH_BITS-1:0]+k) mod depth; upper address bits ignored.
REQ-011 Transfer SHALL occur only in a cycle with avl_ready=1 and the request high; requests with avl_ready=0 SHALL be held by initiator and ignored by responder.
REQ-012 Write FSM states IDLE, WR_BURST; IDLE->WR_BURST on accepted first write beat with burstcount>1; WR_BURST->IDLE after last beat accepted.
REQ-013 First write beat SHALL be accepted only in IDLE, with avl_burstbegin=1, read queue empty and read engine idle (strong ordering: writes never overtake or race pending reads).
REQ-014 In WR_BURST avl_ready SHALL be 1; avl_addr, avl_size, avl_burstbegin ignored; avl_read_req not accepted.
REQ-015 Each accepted write beat SHALL update only bytes with avl_be bit set, visible to any later-accepted read.
REQ-016 Read command SHALL be accepted in IDLE when queue count < 2**RQ_DEPTH_LOG; avl_ready = that condition OR (state==WR_BURST) OR write-acceptable condition of REQ-013.
REQ-017 Read accepted at cycle T SHALL produce burstcount beats with avl_rdata_valid=1 in consecutive cycles, first beat at max(T+READ_LATENCY, previous read's last beat + 1).
REQ-018 Read beats SHALL return in command order, back-to-back bursts with no gap when latency already satisfied.
REQ-019 avl_rdata SHALL hold last valid beat when avl_rdata_valid=0.
REQ-020 avl_read_req and avl_write_req both high in IDLE: neither accepted, avl_ready=0 that cycle, proto_err set.
REQ-021 Burstcount 0 or write first beat without avl_burstbegin: command accepted and discarded, no memory/read effect, proto_err set.
REQ-022 Address wrap within a burst SHALL wrap to word 0 without error.

Reset
REQ-023 While reset=0: avl_ready=0, avl_rdata_valid=0, avl_rdata=0, proto_err=0, FSM IDLE, queue empty, counters 0; memory contents unchanged.
REQ-024 Reset asserted mid-burst SHALL abort write and read bursts; no avl_rdata_valid after reset edge until a new read is accepted.

Configuration
REQ-025 Macro AVL_RESP_RANDSTALL_EN defined: 16-bit LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1 at reset, advances every cycle) SHALL force avl_ready=0 whenever LFSR bit0=1, including in WR_BURST.
REQ-026 Macro undefined: no LFSR logic; avl_ready per REQ-013/014/016 only.

Verification
REQ-027 Write addr 0x10, size 1, be all-ones, data 0xA5..A5; read addr 0x10 size 1 at T -> rdata_valid at T+4, rdata 0xA5..A5.
REQ-028 Write burst addr 0x3FE size 4 data 1,2,3,4 -> words 0x3FE,0x3FF,0x000,0x001 = 1,2,3,4; size-4 read from 0x3FE returns 1,2,3,4 in 4 consecutive cycles.
REQ-029 Five reads size 2 back-to-back -> fifth sees avl_ready=0 until first drains; 10 valid beats, order preserved, no gaps after first.
REQ-030 Word holds 0xFF..FF; write be=0x00000001 data 0 -> readback 0xFF..FF00.
REQ-031 read_req and write_req high together in IDLE -> avl_ready=0, proto_err=1 persists until reset=0.
REQ-032 reset=0 during third beat of size-4 read -> rdata_valid=0 next cycle and stays 0; avl_ready=0 during reset.
